ac_motor_vf_ramp_control: RTL

// Sequences the SVPWM chain (sine/sector gen -> vector time -> vector control -> switch control).

---
 rtl/ac_motor_pkg.sv | 39 +++
 rtl/ac_motor_vf_law.sv | 51 +++++
 rtl/ac_motor_vf_ramp_control.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ac_motor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ac_motor_pkg
//  Description : Shared widths, state encodings and ramp-step helper for the
//                AC motor V/f ramp controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ac_motor_pkg;

    localparam int FREQ_W   = 12;
    localparam int USTR_W   = 12;
    localparam int USTR_MAX = 4095;
    localparam int STATE_W  = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_START = 3'd1;
    localparam logic [STATE_W-1:0] ST_RAMP  = 3'd2;
    localparam logic [STATE_W-1:0] ST_RUN   = 3'd3;
    localparam logic [STATE_W-1:0] ST_STOP  = 3'd4;
    localparam logic [STATE_W-1:0] ST_FAULT = 3'd5;

    // One step toward the target that never overshoots it.
    function automatic logic [FREQ_W-1:0] step_toward(
        input logic [FREQ_W-1:0] i_freq,
        input logic [FREQ_W-1:0] i_tgt,
        input logic [FREQ_W:0]   i_step
    );
        logic [FREQ_W:0] w_gap;
        if (i_freq < i_tgt) begin
            w_gap = {1'b0, i_tgt} - {1'b0, i_freq};
            step_toward = (w_gap > i_step) ? (i_freq + i_step[FREQ_W-1:0]) : i_tgt;
        end else begin
            w_gap = {1'b0, i_freq} - {1'b0, i_tgt};
            step_toward = (w_gap > i_step) ? (i_freq - i_step[FREQ_W-1:0]) : i_tgt;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/ac_motor_vf_law.sv
`default_nettype none
// ============================================================================
//  Module      : ac_motor_vf_law
//  Description : Registered V/f mapping frequency -> u_str with gain, boost
//                offset and saturation; state-dependent forcing.
//  Revision    : 1.0 - initial release
// ============================================================================
module ac_motor_vf_law
    import ac_motor_pkg::*;
#(
    parameter int VF_GAIN = 256,
    parameter int V_BOOST = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] i_state,
    input  logic [FREQ_W-1:0]  i_frequency,
    output logic [USTR_W-1:0]  o_u_str
);

    // Product and sum are sized from the gain so no code ever wraps.
    localparam int PROD_W = FREQ_W + $clog2(VF_GAIN + 1);
    localparam int SUM_W  = PROD_W + 1;

    logic [PROD_W-1:0] w_prod;
    logic [SUM_W-1:0]  w_sum;
    logic [USTR_W-1:0] w_sat;
    logic [USTR_W-1:0] r_u_str;

    always_comb begin
        w_prod = PROD_W'(i_frequency) * PROD_W'(VF_GAIN);
        w_sum  = SUM_W'(w_prod >> 8) + SUM_W'(V_BOOST);
        w_sat  = (w_sum > SUM_W'(USTR_MAX)) ? USTR_W'(USTR_MAX) : w_sum[USTR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_u_str <= '0;
        end else begin
            case (i_state)
                ST_START:                r_u_str <= USTR_W'(V_BOOST);
                ST_RAMP, ST_RUN, ST_STOP: r_u_str <= w_sat;
                default:                 r_u_str <= '0;
            endcase
        end
    end

    assign o_u_str = r_u_str;

endmodule
`default_nettype wire

// File: rtl/ac_motor_vf_ramp_control.sv
`default_nettype none
// ============================================================================
//  Module      : ac_motor_vf_ramp_control
//  Description : Soft-start / linear-ramp / V/f sequencer driving frequency,
//                u_str and pwm_en of the SVPWM chain from a target speed.
//  Revision    : 1.0 - initial release
// ============================================================================
module ac_motor_vf_ramp_control
    import ac_motor_pkg::*;
#(
    parameter int F_MAX        = 4095,
    parameter int F_STEP       = 1,
    parameter int RAMP_DIV     = 1000,
    parameter int VF_GAIN      = 256,
    parameter int V_BOOST      = 200,
    parameter int BOOST_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               fault,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [FREQ_W-1:0]  f_target,
    output logic [FREQ_W-1:0]  frequency,
    output logic [USTR_W-1:0]  u_str,
    output logic               pwm_en,
    output logic               at_speed,
    output logic [STATE_W-1:0] state
);

    localparam int PRESC_W = $clog2(RAMP_DIV + 1);
    localparam int BOOST_W = $clog2(BOOST_CYCLES + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RAMP_DIV - 1);
    localparam logic [BOOST_W-1:0] BOOST_LAST = BOOST_W'(BOOST_CYCLES - 1);
    localparam logic [FREQ_W:0]    STEP_VAL   = (FREQ_W + 1)'(F_STEP);
    localparam logic [FREQ_W-1:0]  FMAX_VAL   = FREQ_W'(F_MAX);

    logic [STATE_W-1:0] r_state;
    logic [FREQ_W-1:0]  r_freq;
    logic [FREQ_W-1:0]  r_tgt;
    logic [PRESC_W-1:0] r_presc;
    logic [BOOST_W-1:0] r_boost;
    logic               r_pwm_en;
    logic               r_at_speed;
    logic               r_cmd_ready;

    logic [STATE_W-1:0] w_state_next;
    logic [FREQ_W-1:0]  w_freq_next;
    logic [FREQ_W-1:0]  w_tgt_next;
    logic [FREQ_W-1:0]  w_ramp_tgt;
    logic [FREQ_W-1:0]  w_stepped;
    logic [FREQ_W-1:0]  w_freq_tick;
    logic [PRESC_W-1:0] w_presc_next;
    logic               w_tick;
    logic               w_cmd_accept;
    logic               w_ramping;

    // Command capture, ramp tick and candidate step
    always_comb begin
        w_cmd_accept = cmd_valid && r_cmd_ready && !fault;
        w_tgt_next   = r_tgt;
        if (w_cmd_accept) begin
            w_tgt_next = (f_target > FMAX_VAL) ? FMAX_VAL : f_target;
        end
        w_ramping   = (r_state == ST_RAMP) || (r_state == ST_STOP);
        w_tick      = w_ramping && (r_presc == PRESC_LAST);
        w_ramp_tgt  = (r_state == ST_STOP) ? '0 : r_tgt;
        w_stepped   = step_toward(r_freq, w_ramp_tgt, STEP_VAL);
        w_freq_tick = w_tick ? w_stepped : r_freq;
    end

    // Next-state / next-frequency; fault beats run, run beats the tick
    always_comb begin
        w_state_next = r_state;
        w_freq_next  = r_freq;
        if (fault) begin
            w_state_next = ST_FAULT;
            w_freq_next  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_freq_next = '0;
                    if (run) w_state_next = ST_START;
                end
                ST_START: begin
                    w_freq_next = '0;
                    if (!run)                       w_state_next = ST_STOP;
                    else if (r_boost == BOOST_LAST) w_state_next = ST_RAMP;
                end
                ST_RAMP: begin
                    if (!run) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_freq_next = w_freq_tick;
                        if (w_freq_tick == r_tgt) w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!run)                w_state_next = ST_STOP;
                    else if (r_freq != r_tgt) w_state_next = ST_RAMP;
                end
                ST_STOP: begin
                    if (run) begin
                        w_state_next = ST_RAMP;
                    end else begin
                        w_freq_next = w_freq_tick;
                        if (w_freq_tick == '0) w_state_next = ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    w_freq_next = '0;
                    if (!run) w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_FAULT;
                    w_freq_next  = '0;
                end
            endcase
        end
    end

    // Prescaler restarts on every entry into RAMP or STOP
    always_comb begin
        w_presc_next = '0;
        if (((w_state_next == ST_RAMP) || (w_state_next == ST_STOP)) && (w_state_next == r_state)) begin
            w_presc_next = w_tick ? '0 : (r_presc + PRESC_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_freq      <= '0;
            r_tgt       <= '0;
            r_presc     <= '0;
            r_boost     <= '0;
            r_pwm_en    <= 1'b0;
            r_at_speed  <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_freq      <= w_freq_next;
            r_tgt       <= w_tgt_next;
            r_presc     <= w_presc_next;
            r_boost     <= ((r_state == ST_START) && (w_state_next == ST_START)) ?
                           (r_boost + BOOST_W'(1)) : '0;
            r_pwm_en    <= (w_state_next inside {ST_START, ST_RAMP, ST_RUN, ST_STOP});
            r_at_speed  <= (w_state_next == ST_RUN) && (w_freq_next == w_tgt_next);
            r_cmd_ready <= (w_state_next != ST_FAULT);
        end
    end

    ac_motor_vf_law #(
        .VF_GAIN (VF_GAIN),
        .V_BOOST (V_BOOST)
    ) u_vf_law (
        .clk         (clk),
        .rst         (rst),
        .i_state     (r_state),
        .i_frequency (r_freq),
        .o_u_str     (u_str)
    );

    assign frequency = r_freq;
    assign pwm_en    = r_pwm_en;
    assign at_speed  = r_at_speed;
    assign cmd_ready = r_cmd_ready;
    assign state     = r_state;

endmodule
`default_nettype wire
